// File: rtl/theta_slice_stage.sv
// Theta column-parity mixing stage: loads one frame of DEPTH 25-bit slices, then
// emits each slice XORed with the parities of its neighbouring columns (z wraps).
module theta_slice_stage #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_line,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_line,
    output logic        out_last,
    output logic        busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; flush in the same cycle cancels it. Outputs hold while ready is low.
    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_cnt, rd_cnt, rd_prev;
    logic [24:0]   slice_mem [DEPTH];
    logic [4:0]    par_mem   [DEPTH];
    logic [4:0]    par_in, par_cur, par_prev, theta_col;
    logic          in_fire, out_fire, wr_end, rd_end;

    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = out_valid & out_ready & ~flush;
    assign wr_end   = (wr_cnt == AW'(DEPTH - 1));
    assign rd_end   = (rd_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (in_fire && wr_end)  state_nxt = EMIT;
                EMIT:    if (out_fire && rd_end) state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == EMIT);
        out_last  = (state == EMIT) && rd_end;
        busy      = (state != LOAD) || (wr_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire)  wr_cnt <= wr_end ? '0 : wr_cnt + AW'(1);
            if (out_fire) rd_cnt <= rd_end ? '0 : rd_cnt + AW'(1);
        end
    end

    // Column parity of the incoming slice: XOR of the five rows for each x.
    always_comb begin
        par_in = '0;
        for (int x = 0; x < 5; x++) begin
            par_in[x] = in_line[x] ^ in_line[5 + x] ^ in_line[10 + x]
                      ^ in_line[15 + x] ^ in_line[20 + x];
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            slice_mem[wr_cnt] <= in_line;
            par_mem[wr_cnt]   <= par_in;
        end
    end

    // DEPTH is a power of two, so rd_cnt-1 wraps 0 to DEPTH-1 for free.
    assign rd_prev  = rd_cnt - AW'(1);
    assign par_cur  = par_mem[rd_cnt];
    assign par_prev = par_mem[rd_prev];

    always_comb begin
        theta_col = '0;
        for (int x = 0; x < 5; x++) begin
            theta_col[x] = par_cur[(x + 4) % 5] ^ par_prev[(x + 1) % 5];
        end
        out_line = '0;
        if (state == EMIT) begin
            out_line = slice_mem[rd_cnt] ^ {5{theta_col}};
        end
    end

endmodule

// File: tb/tb_theta_slice_stage.sv
// Directed bench for theta_slice_stage: stimulus pushes hand-computed results into
// exp_q, and an independent monitor pops and compares on every output transfer.
module tb_theta_slice_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_line = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [24:0] out_line;
  logic        out_last;
  logic        busy;

  logic [25:0] exp_q[$];
  logic [24:0] frame [DEPTH];
  int          n_compared = 0;
  int          n_failed = 0;
  int          out_cnt = 0;

  theta_slice_stage #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
    .out_last(out_last), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {6'd0, out_last, out_line}, 32'hFFFF_FFFF);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check($sformatf("out_slice_%0d", out_cnt % DEPTH), {6'd0, out_last, out_line}, {6'd0, e});
      end
      out_cnt++;
    end
  end

  // driver tasks
  task automatic set_frame_single(input int k);
    for (int z = 0; z < DEPTH; z++) frame[z] = (z == k) ? 25'h0000001 : 25'h0;
  endtask

  task automatic push_single(input int k, input int n);
    logic [24:0] v;
    for (int z = 0; z < n; z++) begin
      if (z == k)                    v = 25'h0210843;
      else if (z == (k + 1) % DEPTH) v = 25'h1084210;
      else                           v = 25'h0;
      exp_q.push_back({(z == DEPTH - 1), v});
    end
  endtask

  task automatic send_slices(input int n);
    logic ok;
    int   tries;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_line  = frame[i];
      tries    = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        tries++;
      end while (!ok && tries < 200);
      if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_line  = '0;
  endtask

  task automatic wait_out(input int target, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (out_cnt >= target) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("output_timeout", out_cnt, target);
    @(posedge clk);
    #1;
  endtask

  task automatic end_of_frame(input string name);
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_out_valid_after"}, out_valid, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int base;
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_line", out_line, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // all-zero frame, out_last only on slice 63
    for (int z = 0; z < DEPTH; z++) begin
      frame[z] = 25'h0;
      exp_q.push_back({(z == DEPTH - 1), 25'h0});
    end
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + DEPTH, 300);
    end_of_frame("t1");

    // single bit in slice 0
    set_frame_single(0);
    push_single(0, DEPTH);
    base = out_cnt;
    send_slices(DEPTH);
    check("t2_in_ready_in_emit", in_ready, 0);
    check("t2_busy_in_emit", busy, 1);
    wait_out(base + DEPTH, 300);
    end_of_frame("t2");

    // single bit in slice 63: parity wraps into slice 0
    set_frame_single(DEPTH - 1);
    push_single(DEPTH - 1, DEPTH);
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + DEPTH, 300);
    end_of_frame("t3");

    // backpressure at slice 1, with in_valid pushed during EMIT
    set_frame_single(0);
    push_single(0, DEPTH);
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + 1, 300);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_line   = 25'h1ABCDEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_line", out_line, 25'h1084210);
      check("t4_stall_last", out_last, 0);
      check("t4_stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_line   = '0;
    out_ready = 1'b1;
    wait_out(base + DEPTH, 300);
    end_of_frame("t4");

    // reset while emitting slice 30
    set_frame_single(0);
    push_single(0, 30);
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + 30, 300);
    rst = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_line", out_line, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_ready_release", in_ready, 1);
    check("t5_busy_release", busy, 0);
    @(posedge clk);
    #1;
    push_single(0, DEPTH);
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + DEPTH, 300);
    end_of_frame("t5");

    // flush after 20 slices, with a handshake offered alongside flush
    for (int z = 0; z < DEPTH; z++) frame[z] = 25'h1555555 ^ 25'(z);
    send_slices(20);
    check("t6_busy_before_flush", busy, 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_line  = 25'h0000001;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_line  = '0;
    check("t6_busy_after_flush", busy, 0);
    check("t6_in_ready_after_flush", in_ready, 1);
    check("t6_out_valid_after_flush", out_valid, 0);
    set_frame_single(DEPTH - 1);
    push_single(DEPTH - 1, DEPTH);
    base = out_cnt;
    send_slices(DEPTH);
    wait_out(base + DEPTH, 300);
    end_of_frame("t6");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
